// File: rtl/ads1118_scan_ctrl_if.sv
// ADS1118 scan controller bus: scan control, SPI pins and tagged conversion results.
interface ads1118_scan_ctrl_if;
  logic        en;
  logic [3:0]  ch_mask;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic        cs_n;
  logic [15:0] data;
  logic [1:0]  data_ch;
  logic        data_valid;
  logic        busy;
  logic        timeout_err;

  modport master (
    input  en, ch_mask, miso,
    output sclk, mosi, cs_n, data, data_ch, data_valid, busy, timeout_err
  );

  modport slave (
    output en, ch_mask, miso,
    input  sclk, mosi, cs_n, data, data_ch, data_valid, busy, timeout_err
  );
endinterface

// File: rtl/ads1118_scan_ctrl.sv
// ADS1118 round-robin scan controller: per-channel config write, DRDY wait, 16-bit SPI mode-1 frame,
// results tagged with the channel configured one frame earlier.
module ads1118_scan_ctrl #(
  parameter int unsigned CLK_DIV  = 50,
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CS_GAP   = 64,
  parameter logic [15:0] CFG_BASE = 16'h82EB,
  parameter int unsigned DRDY_TO  = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  ads1118_scan_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, GAP, WAIT_DRDY, SHIFT, HOLD} state_t;

  localparam int unsigned MAX_LIM = (DRDY_TO > CS_GAP)
                                    ? ((DRDY_TO > CLK_DIV) ? DRDY_TO : CLK_DIV)
                                    : ((CS_GAP > CLK_DIV) ? CS_GAP : CLK_DIV);
  localparam int unsigned CW = $clog2(MAX_LIM + 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] TO_LIM   = CW'(DRDY_TO);
  localparam logic [3:0]    VMASK    = 4'((32'd1 << NUM_CH) - 32'd1);
  localparam logic [1:0]    LAST_CH  = 2'(NUM_CH - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   cfg_q, cfg_d;
  logic [15:0]   shift_q, shift_d;
  logic [1:0]    ch_q, ch_d;
  logic [1:0]    ch_ptr_q, ch_ptr_d;
  logic [1:0]    prev_ch_q, prev_ch_d;
  logic          prev_valid_q, prev_valid_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          cs_n_q, cs_n_d;
  logic          busy_q, busy_d;
  logic [15:0]   data_q, data_d;
  logic [1:0]    data_ch_q, data_ch_d;
  logic          data_valid_q, data_valid_d;
  logic          timeout_q, timeout_d;
  logic          miso_s1, miso_s2;
  logic [3:0]    eff_mask;
  logic [1:0]    nxt_ch;

  // First enabled channel at or above the pointer, otherwise wrap to the lowest enabled one.
  function automatic logic [1:0] pick_ch(input logic [3:0] m, input logic [1:0] from);
    logic [1:0] sel;
    logic       hit;
    sel = '0;
    hit = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!hit && m[k[1:0]] && (k >= 32'(from))) begin
        sel = k[1:0];
        hit = 1'b1;
      end
    end
    for (int unsigned k = 0; k < 4; k++) begin
      if (!hit && m[k[1:0]]) begin
        sel = k[1:0];
        hit = 1'b1;
      end
    end
    return sel;
  endfunction

  assign eff_mask = bus.ch_mask & VMASK;
  assign nxt_ch   = pick_ch(eff_mask, ch_ptr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_s1 <= 1'b1;
      miso_s2 <= 1'b1;
    end else begin
      miso_s1 <= bus.miso;
      miso_s2 <= miso_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      cfg_q        <= '0;
      shift_q      <= '0;
      ch_q         <= '0;
      ch_ptr_q     <= '0;
      prev_ch_q    <= '0;
      prev_valid_q <= 1'b0;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      busy_q       <= 1'b0;
      data_q       <= '0;
      data_ch_q    <= '0;
      data_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      cfg_q        <= cfg_d;
      shift_q      <= shift_d;
      ch_q         <= ch_d;
      ch_ptr_q     <= ch_ptr_d;
      prev_ch_q    <= prev_ch_d;
      prev_valid_q <= prev_valid_d;
      sclk_q       <= sclk_d;
      mosi_q       <= mosi_d;
      cs_n_q       <= cs_n_d;
      busy_q       <= busy_d;
      data_q       <= data_d;
      data_ch_q    <= data_ch_d;
      data_valid_q <= data_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    cfg_d        = cfg_q;
    shift_d      = shift_q;
    ch_d         = ch_q;
    ch_ptr_d     = ch_ptr_q;
    prev_ch_d    = prev_ch_q;
    prev_valid_d = prev_valid_q;
    sclk_d       = sclk_q;
    mosi_d       = mosi_q;
    cs_n_d       = cs_n_q;
    busy_d       = busy_q;
    data_d       = data_q;
    data_ch_d    = data_ch_q;
    data_valid_d = 1'b0;
    timeout_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.en && (eff_mask != '0)) begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end

      GAP: begin
        if (cnt_q >= GAP_LAST) begin
          if (!bus.en || (eff_mask == '0)) begin
            state_d      = IDLE;
            prev_valid_d = 1'b0;
          end else begin
            ch_d    = nxt_ch;
            cfg_d   = CFG_BASE | {1'b0, 3'(3'b100 + {1'b0, nxt_ch}), 12'h000};
            cs_n_d  = 1'b0;
            busy_d  = 1'b1;
            cnt_d   = '0;
            state_d = WAIT_DRDY;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      WAIT_DRDY: begin
        if (!miso_s2) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
          mosi_d  = cfg_q[15];
        end else if (cnt_q >= TO_LIM) begin
          // ch_ptr is untouched, so the next GAP selects the same channel again.
          timeout_d    = 1'b1;
          cs_n_d       = 1'b1;
          busy_d       = 1'b0;
          prev_valid_d = 1'b0;
          cnt_d        = '0;
          state_d      = GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            mosi_d = cfg_q[4'd15 - bit_q];
          end else begin
            sclk_d  = 1'b0;
            shift_d = {shift_q[14:0], miso_s2};
            bit_d   = bit_q + 4'd1;
            if (bit_q == 4'd15) begin
              state_d = HOLD;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      HOLD: begin
        if (cnt_q >= DIV_LAST) begin
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          mosi_d  = 1'b0;
          cnt_d   = '0;
          state_d = GAP;
          // Bits just read belong to the conversion configured in the previous frame.
          if (prev_valid_q) begin
            data_d       = shift_q;
            data_ch_d    = prev_ch_q;
            data_valid_d = 1'b1;
          end
          prev_ch_d    = ch_q;
          prev_valid_d = 1'b1;
          ch_ptr_d     = (ch_q >= LAST_CH) ? '0 : ch_q + 2'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.sclk        = sclk_q;
  assign bus.mosi        = mosi_q;
  assign bus.cs_n        = cs_n_q;
  assign bus.busy        = busy_q;
  assign bus.data        = data_q;
  assign bus.data_ch     = data_ch_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.timeout_err = timeout_q;

endmodule
